// File: rtl/jelly_wishbone_to_axi4l.sv
// Purpose     : WISHBONE classic slave to AXI4-Lite master bridge, one transaction in flight.
// Latency     : stb to ack is 3 cycles minimum (zero-wait slave), longer by any AXI ready/valid wait.
// Backpressure: each AXI valid holds until its ready is sampled; the WISHBONE master waits on ack.
//
// Ports:
//   aclk, aresetn          single shared clock, synchronous active-low reset
//   s_wb_*                 WISHBONE classic slave (word address, byte selects, one-cycle ack)
//   m_axi4l_aw*/w*/b*      AXI4-Lite write address / write data / write response
//   m_axi4l_ar*/r*         AXI4-Lite read address / read data
// Optional build macro JELLY_WISHBONE_TO_AXI4L_ERR_EN adds s_wb_err_o; a SLVERR/DECERR
// response then pulses err instead of ack.

module jelly_wishbone_to_axi4l #(
    parameter int          AXI4L_ADDR_WIDTH = 32,
    parameter int          AXI4L_DATA_SIZE  = 2,
    parameter logic [2:0]  AXI4L_PROT       = 3'b000,
    localparam int         AXI4L_DATA_WIDTH = 8 << AXI4L_DATA_SIZE,
    localparam int         AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH / 8,
    localparam int         WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - AXI4L_DATA_SIZE
) (
    input  logic                         aresetn,
    input  logic                         aclk,

    input  logic [WB_ADR_WIDTH-1:0]      s_wb_adr_i,
    input  logic [AXI4L_DATA_WIDTH-1:0]  s_wb_dat_i,
    output logic [AXI4L_DATA_WIDTH-1:0]  s_wb_dat_o,
    input  logic                         s_wb_we_i,
    input  logic [AXI4L_STRB_WIDTH-1:0]  s_wb_sel_i,
    input  logic                         s_wb_stb_i,
    output logic                         s_wb_ack_o,
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
    output logic                         s_wb_err_o,
`endif

    output logic [AXI4L_ADDR_WIDTH-1:0]  m_axi4l_awaddr,
    output logic [2:0]                   m_axi4l_awprot,
    output logic                         m_axi4l_awvalid,
    input  logic                         m_axi4l_awready,
    output logic [AXI4L_DATA_WIDTH-1:0]  m_axi4l_wdata,
    output logic [AXI4L_STRB_WIDTH-1:0]  m_axi4l_wstrb,
    output logic                         m_axi4l_wvalid,
    input  logic                         m_axi4l_wready,
    input  logic [1:0]                   m_axi4l_bresp,
    input  logic                         m_axi4l_bvalid,
    output logic                         m_axi4l_bready,
    output logic [AXI4L_ADDR_WIDTH-1:0]  m_axi4l_araddr,
    output logic [2:0]                   m_axi4l_arprot,
    output logic                         m_axi4l_arvalid,
    input  logic                         m_axi4l_arready,
    input  logic [AXI4L_DATA_WIDTH-1:0]  m_axi4l_rdata,
    input  logic [1:0]                   m_axi4l_rresp,
    input  logic                         m_axi4l_rvalid,
    output logic                         m_axi4l_rready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_BRESP,
        ST_READ,
        ST_RRESP,
        ST_ACK
    } state_t;

    state_t                         state_q,   state_d;
    logic [AXI4L_ADDR_WIDTH-1:0]    addr_q,    addr_d;
    logic [AXI4L_DATA_WIDTH-1:0]    wdata_q,   wdata_d;
    logic [AXI4L_STRB_WIDTH-1:0]    wstrb_q,   wstrb_d;
    logic [AXI4L_DATA_WIDTH-1:0]    rdata_q,   rdata_d;
    logic                           awvalid_q, awvalid_d;
    logic                           wvalid_q,  wvalid_d;
    logic                           bready_q,  bready_d;
    logic                           arvalid_q, arvalid_d;
    logic                           rready_q,  rready_d;
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
    logic                           err_q,     err_d;
`endif

    // Response codes have no consumer for some bits (all bits in the default build).
    logic unused_resp;
    assign unused_resp = ^{m_axi4l_bresp, m_axi4l_rresp};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
        err_d     = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (s_wb_stb_i) begin
                    // Word address to byte address; a shift keeps DATA_SIZE=0 legal.
                    addr_d = AXI4L_ADDR_WIDTH'(s_wb_adr_i) << AXI4L_DATA_SIZE;
                    if (s_wb_we_i) begin
                        wdata_d   = s_wb_dat_i;
                        wstrb_d   = s_wb_sel_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                // AW and W retire independently; move on once neither is pending,
                // counting handshakes that complete in this very cycle.
                awvalid_d = awvalid_q & ~m_axi4l_awready;
                wvalid_d  = wvalid_q  & ~m_axi4l_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_BRESP;
                end
            end

            ST_BRESP: begin
                if (m_axi4l_bvalid) begin
                    bready_d = 1'b0;
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
                    err_d    = m_axi4l_bresp[1];
`endif
                    state_d  = ST_ACK;
                end
            end

            ST_READ: begin
                if (m_axi4l_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RRESP;
                end
            end

            ST_RRESP: begin
                if (m_axi4l_rvalid) begin
                    rdata_d  = m_axi4l_rdata;
                    rready_d = 1'b0;
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
                    err_d    = m_axi4l_rresp[1];
`endif
                    state_d  = ST_ACK;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // Completion pulse is gated by stb so a master that abandoned the cycle sees nothing.
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
    assign s_wb_ack_o = (state_q == ST_ACK) && s_wb_stb_i && !err_q;
    assign s_wb_err_o = (state_q == ST_ACK) && s_wb_stb_i &&  err_q;
`else
    assign s_wb_ack_o = (state_q == ST_ACK) && s_wb_stb_i;
`endif

    assign s_wb_dat_o      = rdata_q;

    assign m_axi4l_awaddr  = addr_q;
    assign m_axi4l_awprot  = AXI4L_PROT;
    assign m_axi4l_awvalid = awvalid_q;
    assign m_axi4l_wdata   = wdata_q;
    assign m_axi4l_wstrb   = wstrb_q;
    assign m_axi4l_wvalid  = wvalid_q;
    assign m_axi4l_bready  = bready_q;
    assign m_axi4l_araddr  = addr_q;
    assign m_axi4l_arprot  = AXI4L_PROT;
    assign m_axi4l_arvalid = arvalid_q;
    assign m_axi4l_rready  = rready_q;

endmodule

// File: tb/tb_jelly_wishbone_to_axi4l.sv
// Purpose     : scoreboard bench for jelly_wishbone_to_axi4l with a delay-programmable AXI4-Lite slave.
// Latency     : expected ack cycle is carried with each queued completion.
// Backpressure: slave ready/valid delays are set per directed vector.

module tb_jelly_wishbone_to_axi4l;

    logic        aclk;
    logic        aresetn;
    logic [29:0] s_wb_adr_i;
    logic [31:0] s_wb_dat_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_we_i;
    logic [3:0]  s_wb_sel_i;
    logic        s_wb_stb_i;
    logic        s_wb_ack_o;
    logic        wb_err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    jelly_wishbone_to_axi4l dut (
        .aresetn         (aresetn),
        .aclk            (aclk),
        .s_wb_adr_i      (s_wb_adr_i),
        .s_wb_dat_i      (s_wb_dat_i),
        .s_wb_dat_o      (s_wb_dat_o),
        .s_wb_we_i       (s_wb_we_i),
        .s_wb_sel_i      (s_wb_sel_i),
        .s_wb_stb_i      (s_wb_stb_i),
        .s_wb_ack_o      (s_wb_ack_o),
`ifdef JELLY_WISHBONE_TO_AXI4L_ERR_EN
        .s_wb_err_o      (wb_err),
`endif
        .m_axi4l_awaddr  (awaddr),
        .m_axi4l_awprot  (awprot),
        .m_axi4l_awvalid (awvalid),
        .m_axi4l_awready (awready),
        .m_axi4l_wdata   (wdata),
        .m_axi4l_wstrb   (wstrb),
        .m_axi4l_wvalid  (wvalid),
        .m_axi4l_wready  (wready),
        .m_axi4l_bresp   (bresp),
        .m_axi4l_bvalid  (bvalid),
        .m_axi4l_bready  (bready),
        .m_axi4l_araddr  (araddr),
        .m_axi4l_arprot  (arprot),
        .m_axi4l_arvalid (arvalid),
        .m_axi4l_arready (arready),
        .m_axi4l_rdata   (rdata),
        .m_axi4l_rresp   (rresp),
        .m_axi4l_rvalid  (rvalid),
        .m_axi4l_rready  (rready)
    );

`ifndef JELLY_WISHBONE_TO_AXI4L_ERR_EN
    assign wb_err = 1'b0;
    localparam logic ERR_EN = 1'b0;
`else
    localparam logic ERR_EN = 1'b1;
`endif

    typedef struct {
        logic        is_err;
        logic        is_rd;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [31:0] exp_ar[$];
    ack_t        exp_ack[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_wr = 0, n_rd = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    // Slave configuration
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // AXI4-Lite slave: readies/valids after programmable wait counts.
    initial begin
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(posedge aclk); #1;
            if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (aw_hs > b_hs && w_hs > b_hs) begin
                bvalid = (b_cnt >= b_dly); bresp = bresp_cfg; b_cnt++;
            end else begin bvalid = 0; b_cnt = 0; end
            if (ar_hs > r_hs) begin
                rvalid = (r_cnt >= r_dly); rdata = rdata_cfg; rresp = 2'b00; r_cnt++;
            end else begin rvalid = 0; r_cnt = 0; end
        end
    end

    // Monitor: protocol stability plus scoreboard pops on every handshake / completion.
    initial begin
        logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
        logic        p_br = 0, p_bv = 0, p_rr = 0, p_rv = 0;
        logic [31:0] p_awaddr = 0, p_araddr = 0;
        logic [35:0] p_w = 0;
        ack_t        a;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
            end else begin
                if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wr)   chk("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_w});
                if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
                if (p_br && !p_bv)   chk("bready_hold", bready, 1);
                if (p_rr && !p_rv)   chk("rready_hold", rready, 1);

                if (awvalid && awready) begin
                    aw_hs++;
                    chk("aw_expected", exp_aw.size() > 0, 1);
                    if (exp_aw.size() > 0) chk("awaddr", awaddr, exp_aw.pop_front());
                end
                if (wvalid && wready) begin
                    w_hs++;
                    chk("w_expected", exp_w.size() > 0, 1);
                    if (exp_w.size() > 0) chk("wstrb_wdata", {wstrb, wdata}, exp_w.pop_front());
                end
                if (bvalid && bready) b_hs++;
                if (arvalid && arready) begin
                    ar_hs++;
                    chk("ar_expected", exp_ar.size() > 0, 1);
                    if (exp_ar.size() > 0) chk("araddr", araddr, exp_ar.pop_front());
                end
                if (rvalid && rready) r_hs++;

                if (s_wb_ack_o || wb_err) begin
                    chk("ack_expected", exp_ack.size() > 0, 1);
                    if (exp_ack.size() > 0) begin
                        a = exp_ack.pop_front();
                        chk("ack_err_kind", {s_wb_ack_o, wb_err}, {!a.is_err, a.is_err});
                        chk("ack_cycle", cyc, a.cyc);
                        if (a.is_rd) chk("rd_data", s_wb_dat_o, a.rdata);
                    end
                end

                p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
                p_wv = wvalid;   p_wr = wready;   p_w = {wstrb, wdata};
                p_arv = arvalid; p_arr = arready; p_araddr = araddr;
                p_br = bready;   p_bv = bvalid;
                p_rr = rready;   p_rv = rvalid;
            end
        end
    end

    // One WISHBONE request; expected AXI beats and completion go to the scoreboard.
    task automatic wb_xfer(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp_addr,
                           input logic [31:0] rd_exp, input logic exp_err,
                           input int lat, input logic keep);
        ack_t a;
        logic done;
        s_wb_stb_i = 1; s_wb_we_i = we; s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel;
        if (we) begin
            exp_aw.push_back(exp_addr);
            exp_w.push_back({sel, dat});
            n_wr++;
        end else begin
            exp_ar.push_back(exp_addr);
            n_rd++;
        end
        a.is_err = exp_err; a.is_rd = !we; a.rdata = rd_exp; a.cyc = cyc + lat;
        exp_ack.push_back(a);
        done = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge aclk);
            if (s_wb_ack_o || wb_err) done = 1;
        end
        chk("ack_timeout", done, 1);
        @(posedge aclk); #1;
        if (!keep) s_wb_stb_i = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
        end
    endtask

    initial begin
        aresetn = 0; s_wb_stb_i = 0; s_wb_we_i = 0; s_wb_adr_i = 0; s_wb_dat_i = 0; s_wb_sel_i = 0;
        idle(3);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_ack_err", {s_wb_ack_o, wb_err}, 2'b00);
        chk("rst_dat_o", s_wb_dat_o, 32'h0);
        chk("rst_prot", {awprot, arprot}, 6'b0);
        aresetn = 1;
        idle(2);

        // Zero-wait write
        wb_xfer(1, 30'h4, 32'hDEAD_BEEF, 4'hF, 32'h10, 0, 0, 3, 0);
        idle(2);

        // AW delayed by 4, then W delayed by 4
        aw_dly = 4;
        wb_xfer(1, 30'h100, 32'hA5A5_0001, 4'h3, 32'h400, 0, 0, 7, 0);
        aw_dly = 0; w_dly = 4;
        wb_xfer(1, 30'h2A, 32'h0BAD_F00D, 4'hC, 32'hA8, 0, 0, 7, 0);
        w_dly = 0;
        idle(2);

        // Read with rvalid delayed by 6
        r_dly = 6; rdata_cfg = 32'h1234_5678;
        wb_xfer(0, 30'h3, 32'h0, 4'hF, 32'hC, 32'h1234_5678, 0, 9, 0);
        r_dly = 0;
        idle(3);
        chk("rd_data_hold", s_wb_dat_o, 32'h1234_5678);

        // Back-to-back with stb held high across the ack
        rdata_cfg = 32'hCAFE_0042;
        wb_xfer(1, 30'h10, 32'h0000_00FF, 4'h1, 32'h40, 0, 0, 3, 1);
        wb_xfer(0, 30'h11, 32'h0, 4'hF, 32'h44, 32'hCAFE_0042, 0, 3, 0);
        idle(3);

        // stb withdrawn mid-write: AXI side completes, no ack
        aw_dly = 3;
        s_wb_stb_i = 1; s_wb_we_i = 1; s_wb_adr_i = 30'h20; s_wb_dat_i = 32'h1; s_wb_sel_i = 4'hF;
        exp_aw.push_back(32'h80); exp_w.push_back({4'hF, 32'h1}); n_wr++;
        idle(2);
        s_wb_stb_i = 0;
        idle(15);
        aw_dly = 0;

        // SLVERR write response
        bresp_cfg = 2'b10;
        wb_xfer(1, 30'h8, 32'h55, 4'hF, 32'h20, 0, ERR_EN, 3, 0);
        bresp_cfg = 2'b00;
        idle(2);

        // Reset while awvalid is stalled
        aw_dly = 100; w_dly = 100;
        s_wb_stb_i = 1; s_wb_we_i = 1; s_wb_adr_i = 30'h77; s_wb_dat_i = 32'h9; s_wb_sel_i = 4'hF;
        idle(2);
        chk("pre_rst_awvalid", awvalid, 1);
        s_wb_stb_i = 0; aresetn = 0;
        idle(1);
        chk("midrst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("midrst_ack", {s_wb_ack_o, wb_err}, 2'b00);
        chk("midrst_dat_o", s_wb_dat_o, 32'h0);
        aresetn = 1; aw_dly = 0; w_dly = 0;
        idle(2);
        rdata_cfg = 32'h0F0F_0F0F;
        wb_xfer(0, 30'h5, 32'h0, 4'hF, 32'h14, 32'h0F0F_0F0F, 0, 3, 0);
        idle(5);

        chk("left_aw", exp_aw.size(), 0);
        chk("left_w", exp_w.size(), 0);
        chk("left_ar", exp_ar.size(), 0);
        chk("left_ack", exp_ack.size(), 0);
        chk("b_count", b_hs, n_wr);
        chk("r_count", r_hs, n_rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jelly_wishbone_to_axi4l.md
Name: jelly_wishbone_to_axi4l

Overview:
- Bridge from a WISHBONE classic slave port to an AXI4-Lite master port. It is the reverse of the existing AXI4-Lite-to-WISHBONE bridge.
- Lets fabric-side WISHBONE masters (soft CPU, RTOS helpers, DMA sequencers) reach PS slave ports and AXI4-Lite peripherals.
- Handles one outstanding transaction at a time. WISHBONE and AXI sides share one clock.

Parameters:
- AXI4L_ADDR_WIDTH, 32, AXI byte-address width.
- AXI4L_DATA_SIZE, 2, log2 of data bytes (0:8b, 1:16b, 2:32b, 3:64b).
- AXI4L_PROT, 3'b000, constant driven on awprot/arprot.
- Derived, not overridable:
  - AXI4L_DATA_WIDTH = 8<<AXI4L_DATA_SIZE
  - AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH/8
  - WB_ADR_WIDTH = AXI4L_ADDR_WIDTH-AXI4L_DATA_SIZE

Ports:
- aresetn  in  1  synchronous reset, active low
- aclk  in  1  single clock for both sides
- s_wb_adr_i  in  WB_ADR_WIDTH  word address
- s_wb_dat_i  in  AXI4L_DATA_WIDTH  write data
- s_wb_dat_o  out  AXI4L_DATA_WIDTH  read data
- s_wb_we_i  in  1  write enable
- s_wb_sel_i  in  AXI4L_STRB_WIDTH  byte select
- s_wb_stb_i  in  1  strobe
- s_wb_ack_o  out  1  acknowledge, one-cycle pulse
- m_axi4l_awaddr/awprot/awvalid  out  ADDR/3/1; m_axi4l_awready  in  1
- m_axi4l_wdata/wstrb/wvalid  out  DATA/STRB/1; m_axi4l_wready  in  1
- m_axi4l_bresp  in  2; m_axi4l_bvalid  in  1; m_axi4l_bready  out  1
- m_axi4l_araddr/arprot/arvalid  out  ADDR/3/1; m_axi4l_arready  in  1
- m_axi4l_rdata  in  DATA; m_axi4l_rresp  in  2; m_axi4l_rvalid  in  1; m_axi4l_rready  out  1

Behaviour:
- Reset is synchronous and active-low: aresetn sampled low at a rising aclk edge resets the block. Reset values:
  - all valid/ready outputs 0
  - s_wb_ack_o 0, s_wb_dat_o 0
  - state IDLE
  - address/data/strobe registers 0
- Reset mid-transaction drops all valids immediately. System reset must cover the AXI slave.
- State machine: IDLE, WRITE, BRESP, READ, RRESP, ACK.
- IDLE with stb=1, we=1:
  - latch awaddr={adr,AXI4L_DATA_SIZE'b0}, wdata=dat_i, wstrb=sel_i
  - assert awvalid and wvalid next cycle; go to WRITE
- WRITE:
  - awvalid drops after the cycle awvalid&awready is sampled; wvalid likewise, independently. AW and W may complete in either order or in the same cycle.
  - When both are done: assert bready, go to BRESP.
- BRESP: on bvalid&bready, drop bready and go to ACK.
- IDLE with stb=1, we=0: latch araddr, assert arvalid next cycle, go to READ.
- READ: on arvalid&arready, drop arvalid, assert rready, go to RRESP.
- RRESP: on rvalid&rready, register rdata into s_wb_dat_o, drop rready, go to ACK.
- ACK: s_wb_ack_o=1 for exactly one cycle, then IDLE.
- After ack, a stb still high in IDLE is treated as a new request. The master must have updated or dropped it per WISHBONE classic.
- s_wb_dat_o holds its last read value until the next read completes.
- Minimum latency, zero-wait slave, stb rising at cycle 0:
  - write: aw/w valid at cycle 1, bvalid sampled at cycle 2, ack at cycle 3
  - read: arvalid at cycle 1, rvalid at cycle 2, ack at cycle 3
- Valid outputs never drop before their ready is sampled high. Address, data and strobe stay stable while their valid is high.
- stb deasserted mid-transaction (protocol violation): the AXI transaction still completes, and the ACK pulse is suppressed if stb=0 in the ACK cycle.
- bresp/rresp values other than OKAY are ignored unless the optional feature is enabled; the transfer still acks.

Optional Feature:
- Macro: JELLY_WISHBONE_TO_AXI4L_ERR_EN.
- Defined:
  - adds port s_wb_err_o (out, 1, reset 0)
  - a response with resp[1]=1 (SLVERR/DECERR) pulses s_wb_err_o instead of s_wb_ack_o in the ACK state
  - read data is still latched
- Undefined: no err port; every completion pulses ack.

Test Plan:
- Write, zero-wait slave: adr=0x0000_0004, dat=0xDEAD_BEEF, sel=4'hF → awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; ack one cycle, 3 cycles after stb.
- Write, aw and w handshakes split:
  - awready delayed 4 cycles, wready immediate → wvalid drops after its handshake, awvalid holds until cycle 5, exactly one B handshake, one ack.
  - Repeat with the order reversed.
- Read, rvalid delayed 6 cycles, rdata=0x1234_5678 → rready held throughout; s_wb_dat_o=0x12345678 in the ack cycle and after.
- Back-to-back with stb held high: write, then read on the next request → two separate AXI transactions, two ack pulses, no duplicate transaction.
- aresetn low while awvalid=1 and awready=0 → next cycle all valids 0, ack 0, state IDLE; a fresh read after reset completes normally.
- With JELLY_WISHBONE_TO_AXI4L_ERR_EN defined, bresp=2'b10 → s_wb_err_o pulses once and ack stays 0. Without the macro, same stimulus → ack pulses.
